// File: rtl/que_slot_stream_handler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : que_slot_pkg
//  Description : Shared types and constants for the queue-slot stream handler.
//  Revision    : 1.0 - initial release
// ============================================================================
package que_slot_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADVERTISE = 3'd1,
        S_PUSH      = 3'd2,
        S_HOLD      = 3'd3,
        S_WAIT      = 3'd4
    } state_t;

    // Flag positions above the payload: push_data[DATA_WIDTH + <bit>]
    localparam int FIRST_BIT = 0;
    localparam int LAST_BIT  = 1;

    localparam int TIMEOUT_LIMIT_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/que_slot_stream_handler_if.sv
`default_nettype none
// ============================================================================
//  Module      : que_slot_stream_handler_if
//  Description : Slot FIFO / arbiter / downstream signals of the stream handler.
//                Stats outputs present only when QUE_SLOT_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface que_slot_stream_handler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 12
);
    logic                  enable;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_enable;
    logic                  good_packet;
    logic                  bad_packet;
    logic [LEN_WIDTH-1:0]  packet_length;
    logic                  push_data_enable;
    logic                  fifo_reset;
    logic                  ready;
    logic                  push_data_ready;
    logic [DATA_WIDTH+1:0] push_data;
    logic                  push_data_valid;
    logic                  done;
    logic                  timeout_error;
`ifdef QUE_SLOT_STATS_EN
    logic [31:0]           pkt_count;
    logic [31:0]           drop_count;
    logic [31:0]           timeout_count;
`endif

    // master: the handler itself; slave: FIFO, arbiter and downstream side
    modport master (
        input  enable, data, data_enable, good_packet, bad_packet,
               packet_length, push_data_enable,
`ifdef QUE_SLOT_STATS_EN
        output pkt_count, drop_count, timeout_count,
`endif
        output fifo_reset, ready, push_data_ready, push_data,
               push_data_valid, done, timeout_error
    );

    modport slave (
        output enable, data, data_enable, good_packet, bad_packet,
               packet_length, push_data_enable,
`ifdef QUE_SLOT_STATS_EN
        input  pkt_count, drop_count, timeout_count,
`endif
        input  fifo_reset, ready, push_data_ready, push_data,
               push_data_valid, done, timeout_error
    );

endinterface
`default_nettype wire

// File: rtl/que_slot_stream_handler_cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_timer
//  Description : Loadable down-counter; expired flags the last counted tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             tick,
    input  logic [WIDTH-1:0] load_count,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_count;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = tick && (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/que_slot_stream_handler.sv
`default_nettype none
// ============================================================================
//  Module      : que_slot_stream_handler
//  Description : Advertises a checked slot packet and drains it on grant with
//                first/last tagging, stall holding and idle timeout.
//                Optional statistics: define QUE_SLOT_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module que_slot_stream_handler
    import que_slot_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int LEN_WIDTH     = 12,
    parameter int TIMEOUT_LIMIT = TIMEOUT_LIMIT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    que_slot_stream_handler_if.master bus
);

    localparam int c_tmr_w  = $clog2(TIMEOUT_LIMIT + 1);
    localparam int c_word_w = DATA_WIDTH + 2;

    state_t                r_state, w_state_nx;
    logic [LEN_WIDTH-1:0]  r_rd_left, w_rd_left_nx;
    logic [LEN_WIDTH-1:0]  r_wr_left, w_wr_left_nx;
    logic                  r_first, w_first_nx;
    logic [DATA_WIDTH-1:0] r_hold0, w_hold0_nx;
    logic [DATA_WIDTH-1:0] r_hold1, w_hold1_nx;
    logic [1:0]            r_hold_cnt, w_hold_cnt_nx;

    logic                  r_fifo_reset, w_fifo_reset_nx;
    logic                  r_ready, w_ready_nx;
    logic                  r_pdr, w_pdr_nx;
    logic [c_word_w-1:0]   r_push_data, w_push_data_nx;
    logic                  r_pdv, w_pdv_nx;
    logic                  r_done, w_done_nx;
    logic                  r_timeout, w_timeout_nx;

    logic                  w_tmr_load, w_tmr_tick, w_tmr_expired;
    logic                  w_emit;
    logic [DATA_WIDTH-1:0] w_emit_data;
    logic                  w_last, w_rd_more, w_can_rd;

    assign w_last     = (r_wr_left == LEN_WIDTH'(1));
    assign w_rd_more  = (r_rd_left != '0);
    assign w_can_rd   = bus.enable && bus.push_data_enable && w_rd_more;
    assign w_tmr_tick = (r_state == S_PUSH) && !bus.data_enable && bus.push_data_enable;

    cycle_timer #(
        .WIDTH (c_tmr_w)
    ) u_timeout (
        .clock      (clock),
        .reset      (reset),
        .load       (w_tmr_load),
        .tick       (w_tmr_tick),
        .load_count (c_tmr_w'(TIMEOUT_LIMIT)),
        .expired    (w_tmr_expired)
    );

    always_comb begin
        w_state_nx      = r_state;
        w_rd_left_nx    = r_rd_left;
        w_wr_left_nx    = r_wr_left;
        w_first_nx      = r_first;
        w_hold0_nx      = r_hold0;
        w_hold1_nx      = r_hold1;
        w_hold_cnt_nx   = r_hold_cnt;
        w_fifo_reset_nx = 1'b0;
        w_ready_nx      = 1'b0;
        w_pdr_nx        = 1'b0;
        w_push_data_nx  = r_push_data;
        w_pdv_nx        = 1'b0;
        w_done_nx       = 1'b0;
        w_timeout_nx    = 1'b0;
        w_tmr_load      = 1'b0;
        w_emit          = 1'b0;
        w_emit_data     = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.bad_packet || (bus.good_packet && (bus.packet_length == '0))) begin
                    w_fifo_reset_nx = 1'b1;
                end else if (bus.good_packet) begin
                    w_rd_left_nx = bus.packet_length;
                    w_wr_left_nx = bus.packet_length;
                    w_first_nx   = 1'b1;
                    w_ready_nx   = 1'b1;
                    w_state_nx   = S_ADVERTISE;
                end
            end
            S_ADVERTISE: begin
                w_ready_nx = 1'b1;
                if (bus.enable && bus.push_data_enable) begin
                    w_ready_nx = 1'b0;
                    w_pdr_nx   = 1'b1;
                    w_tmr_load = 1'b1;
                    w_state_nx = S_PUSH;
                end
            end
            S_PUSH: begin
                if (bus.data_enable) begin
                    w_tmr_load = 1'b1;
                    if (bus.push_data_enable) begin
                        w_emit      = 1'b1;
                        w_emit_data = bus.data;
                        w_pdr_nx    = w_can_rd;
                    end else begin
                        w_hold0_nx    = bus.data;
                        w_hold_cnt_nx = 2'd1;
                        w_state_nx    = S_HOLD;
                    end
                end else if (!bus.push_data_enable) begin
                    w_state_nx = S_WAIT;
                end else if (w_tmr_expired) begin
                    w_timeout_nx    = 1'b1;
                    w_fifo_reset_nx = 1'b1;
                    w_state_nx      = S_IDLE;
                end else begin
                    w_pdr_nx = w_can_rd;
                end
            end
            S_HOLD: begin
                // A request issued just before the stall can land here, so
                // the hold stage keeps up to two words in arrival order.
                if (bus.push_data_enable) begin
                    w_emit      = 1'b1;
                    w_emit_data = r_hold0;
                    if (r_hold_cnt == 2'd2) begin
                        w_hold0_nx = r_hold1;
                        if (bus.data_enable) begin
                            w_hold1_nx = bus.data;
                        end else begin
                            w_hold_cnt_nx = 2'd1;
                        end
                    end else if (bus.data_enable) begin
                        w_hold0_nx = bus.data;
                    end else begin
                        w_hold_cnt_nx = 2'd0;
                        w_state_nx    = S_PUSH;
                        w_pdr_nx      = w_can_rd;
                    end
                end else if (bus.data_enable && (r_hold_cnt == 2'd1)) begin
                    w_hold1_nx    = bus.data;
                    w_hold_cnt_nx = 2'd2;
                end
            end
            S_WAIT: begin
                if (bus.data_enable) begin
                    w_hold0_nx    = bus.data;
                    w_hold_cnt_nx = 2'd1;
                    w_state_nx    = S_HOLD;
                end else if (bus.push_data_enable && bus.enable) begin
                    w_tmr_load = 1'b1;
                    w_pdr_nx   = w_rd_more;
                    w_state_nx = S_PUSH;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        if (w_emit) begin
            w_push_data_nx                         = '0;
            w_push_data_nx[DATA_WIDTH-1:0]         = w_emit_data;
            w_push_data_nx[DATA_WIDTH + LAST_BIT]  = w_last;
            w_push_data_nx[DATA_WIDTH + FIRST_BIT] = r_first;
            w_pdv_nx     = 1'b1;
            w_wr_left_nx = r_wr_left - LEN_WIDTH'(1);
            w_first_nx   = 1'b0;
            if (w_last) begin
                w_done_nx     = 1'b1;
                w_pdr_nx      = 1'b0;
                w_hold_cnt_nx = 2'd0;
                w_state_nx    = S_IDLE;
            end
        end

        if (w_pdr_nx) begin
            w_rd_left_nx = r_rd_left - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rd_left    <= '0;
            r_wr_left    <= '0;
            r_first      <= 1'b0;
            r_hold0      <= '0;
            r_hold1      <= '0;
            r_hold_cnt   <= 2'd0;
            r_fifo_reset <= 1'b1;
            r_ready      <= 1'b0;
            r_pdr        <= 1'b0;
            r_push_data  <= '0;
            r_pdv        <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_rd_left    <= w_rd_left_nx;
            r_wr_left    <= w_wr_left_nx;
            r_first      <= w_first_nx;
            r_hold0      <= w_hold0_nx;
            r_hold1      <= w_hold1_nx;
            r_hold_cnt   <= w_hold_cnt_nx;
            r_fifo_reset <= w_fifo_reset_nx;
            r_ready      <= w_ready_nx;
            r_pdr        <= w_pdr_nx;
            r_push_data  <= w_push_data_nx;
            r_pdv        <= w_pdv_nx;
            r_done       <= w_done_nx;
            r_timeout    <= w_timeout_nx;
        end
    end

    assign bus.fifo_reset      = r_fifo_reset;
    assign bus.ready           = r_ready;
    assign bus.push_data_ready = r_pdr;
    assign bus.push_data       = r_push_data;
    assign bus.push_data_valid = r_pdv;
    assign bus.done            = r_done;
    assign bus.timeout_error   = r_timeout;

`ifdef QUE_SLOT_STATS_EN
    logic        w_idle_drop;
    logic [31:0] r_pkt_count, r_drop_count, r_timeout_count;

    // Only flushes raised from idle count as drops; timeouts have their own counter
    assign w_idle_drop = (r_state == S_IDLE) && w_fifo_reset_nx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pkt_count     <= '0;
            r_drop_count    <= '0;
            r_timeout_count <= '0;
        end else begin
            if (w_done_nx && (r_pkt_count != '1)) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (w_idle_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
            if (w_timeout_nx && (r_timeout_count != '1)) begin
                r_timeout_count <= r_timeout_count + 32'd1;
            end
        end
    end

    assign bus.pkt_count     = r_pkt_count;
    assign bus.drop_count    = r_drop_count;
    assign bus.timeout_count = r_timeout_count;
`endif

endmodule
`default_nettype wire
